// File: rtl/wb_pkg.sv
// Shared types and widths for the dual-PE writeback path.
//   XLEN       : register data width
//   AW         : register address width
//   NREG       : number of architectural registers (width of the pending vector)
//   wb_entry_t : one buffered result {destination register, data}
package wb_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-PE result FIFO for the writeback unit.
// Optional macro: WB_PENDING_EN adds the rd_mask output (one bit per register
// named by any occupied entry).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears pointers/count)
//   push, push_entry : write one entry (ignored when full)
//   pop           : remove head (ignored when empty)
//   head, head_valid : oldest entry and its valid flag
//   count, full   : occupancy, registered
//   rd_mask       : (WB_PENDING_EN only) destinations held by occupied entries
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
`ifdef WB_PENDING_EN
  ,
  output logic [NREG-1:0]              rd_mask
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full       = (count == DEPTH_C);
  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

`ifdef WB_PENDING_EN
  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) rd_mask[mem[rd_ptr + PW'(i)].rd] = 1'b1;
    end
  end
`endif
endmodule

// File: rtl/dual_pe_writeback_unit.sv
// Write side of the dual-PE register file: buffers PE1/PE2 results in two
// FIFOs and drains them onto two registered register-file write ports,
// never writing the same register on both ports in one cycle and dropping
// writes to x0.
// Optional macro: WB_PENDING_EN builds the in-flight register scoreboard;
// otherwise pending is tied to zero.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_valid/ready/rd/data_pe1, _pe2 : result channels from each PE
//   WE3/A3/WD3_PE1, _PE2             : register-file write ports
//   pending                          : bit r set while a write to r is in flight
module dual_pe_writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_pe1,
  output logic            in_ready_pe1,
  input  logic [AW-1:0]   in_rd_pe1,
  input  logic [XLEN-1:0] in_data_pe1,
  input  logic            in_valid_pe2,
  output logic            in_ready_pe2,
  input  logic [AW-1:0]   in_rd_pe2,
  input  logic [XLEN-1:0] in_data_pe2,
  output logic            WE3_PE1,
  output logic [AW-1:0]   A3_PE1,
  output logic [XLEN-1:0] WD3_PE1,
  output logic            WE3_PE2,
  output logic [AW-1:0]   A3_PE2,
  output logic [XLEN-1:0] WD3_PE2,
  output logic [NREG-1:0] pending
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t       head_pe1, head_pe2;
  logic            hv_pe1, hv_pe2;
  logic [CW-1:0]   cnt_pe1, cnt_pe2;
  logic            full_pe1, full_pe2;
  logic            push_pe1, push_pe2;
  logic            pop_pe1, pop_pe2;
  logic            issue_pe1, issue_pe2;
  logic            collide;
  logic            prio_pe2;
  logic            we_pe1_p1, we_pe2_p1;
  logic [AW-1:0]   a3_pe1_p1, a3_pe2_p1;
  logic [XLEN-1:0] wd3_pe1_p1, wd3_pe2_p1;
  logic            unused_full;

  // Ready follows the registered count, so a full FIFO refuses a push even
  // in a cycle where it also pops.
  assign in_ready_pe1 = !rst && (cnt_pe1 < DEPTH_C);
  assign in_ready_pe2 = !rst && (cnt_pe2 < DEPTH_C);
  assign push_pe1     = in_valid_pe1 && in_ready_pe1;
  assign push_pe2     = in_valid_pe2 && in_ready_pe2;
  assign unused_full  = full_pe1 | full_pe2;

`ifdef WB_PENDING_EN
  logic [NREG-1:0] mask_pe1, mask_pe2, mask_out;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_pe1 (
    .clk        (clk),
    .rst        (rst),
    .push       (push_pe1),
    .push_entry ('{rd: in_rd_pe1, data: in_data_pe1}),
    .pop        (pop_pe1),
    .head       (head_pe1),
    .head_valid (hv_pe1),
    .count      (cnt_pe1),
    .full       (full_pe1)
`ifdef WB_PENDING_EN
    ,
    .rd_mask    (mask_pe1)
`endif
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_pe2 (
    .clk        (clk),
    .rst        (rst),
    .push       (push_pe2),
    .push_entry ('{rd: in_rd_pe2, data: in_data_pe2}),
    .pop        (pop_pe2),
    .head       (head_pe2),
    .head_valid (hv_pe2),
    .count      (cnt_pe2),
    .full       (full_pe2)
`ifdef WB_PENDING_EN
    ,
    .rd_mask    (mask_pe2)
`endif
  );

  // ---- Stage p0: issue arbitration on the FIFO heads ----
  // A same-register collision lets PE1 go first; prio_pe2 then hands the next
  // colliding cycle to PE2 so the older PE2 entry cannot starve and the pair
  // lands PE1-then-PE2.
  assign collide   = hv_pe1 && hv_pe2 && (head_pe1.rd == head_pe2.rd) && (head_pe1.rd != '0);
  assign pop_pe1   = hv_pe1 && !(collide && prio_pe2);
  assign pop_pe2   = hv_pe2 && !(collide && !prio_pe2);
  assign issue_pe1 = pop_pe1 && (head_pe1.rd != '0);
  assign issue_pe2 = pop_pe2 && (head_pe2.rd != '0);

  // ---- Stage p1: registered write ports ----
  always_ff @(posedge clk) begin
    if (rst) begin
      we_pe1_p1 <= 1'b0;
      we_pe2_p1 <= 1'b0;
      prio_pe2  <= 1'b0;
    end else begin
      we_pe1_p1 <= issue_pe1;
      we_pe2_p1 <= issue_pe2;
      prio_pe2  <= collide && !prio_pe2;
    end
  end

  // Address/data are zeroed whenever no write is issued, which also clears
  // them during reset without a reset branch on the datapath.
  always_ff @(posedge clk) begin
    a3_pe1_p1  <= (issue_pe1 && !rst) ? head_pe1.rd   : '0;
    wd3_pe1_p1 <= (issue_pe1 && !rst) ? head_pe1.data : '0;
    a3_pe2_p1  <= (issue_pe2 && !rst) ? head_pe2.rd   : '0;
    wd3_pe2_p1 <= (issue_pe2 && !rst) ? head_pe2.data : '0;
  end

  assign WE3_PE1 = we_pe1_p1;
  assign A3_PE1  = a3_pe1_p1;
  assign WD3_PE1 = wd3_pe1_p1;
  assign WE3_PE2 = we_pe2_p1;
  assign A3_PE2  = a3_pe2_p1;
  assign WD3_PE2 = wd3_pe2_p1;

`ifdef WB_PENDING_EN
  always_comb begin
    mask_out = '0;
    if (we_pe1_p1) mask_out[a3_pe1_p1] = 1'b1;
    if (we_pe2_p1) mask_out[a3_pe2_p1] = 1'b1;
  end
  // x0 is never pending: its writes are discarded.
  assign pending = (mask_pe1 | mask_pe2 | mask_out) & {{(NREG-1){1'b1}}, 1'b0};
`else
  assign pending = '0;
`endif
endmodule

// File: tb/tb_dual_pe_writeback_unit.sv
// Self-checking bench for dual_pe_writeback_unit: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_dual_pe_writeback_unit;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        v1, v2;
  logic [4:0]  rd1, rd2;
  logic [31:0] d1, d2;
  logic        in_ready_pe1, in_ready_pe2;
  logic        WE3_PE1, WE3_PE2;
  logic [4:0]  A3_PE1, A3_PE2;
  logic [31:0] WD3_PE1, WD3_PE2;
  logic [31:0] pending;

  dual_pe_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_pe1 (v1),
    .in_ready_pe1 (in_ready_pe1),
    .in_rd_pe1    (rd1),
    .in_data_pe1  (d1),
    .in_valid_pe2 (v2),
    .in_ready_pe2 (in_ready_pe2),
    .in_rd_pe2    (rd2),
    .in_data_pe2  (d2),
    .WE3_PE1      (WE3_PE1),
    .A3_PE1       (A3_PE1),
    .WD3_PE1      (WD3_PE1),
    .WE3_PE2      (WE3_PE2),
    .A3_PE2       (A3_PE2),
    .WD3_PE2      (WD3_PE2),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        q1[$];
  ent_t        q2[$];
  logic        owed;
  logic        e_we1, e_we2;
  logic [4:0]  e_a1, e_a2;
  logic [31:0] e_d1, e_d2;
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf [32];
  logic        saw_nready2;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input ent_t e, output logic we, output logic [4:0] a, output logic [31:0] d);
    we = (e.rd != 5'd0);
    a  = we ? e.rd : 5'd0;
    d  = we ? e.data : 32'd0;
  endtask

  // One clock: check readiness, advance the model across the edge, then
  // compare the registered outputs one time unit after the edge.
  task automatic step();
    logic        mr1, mr2, acc1, acc2, col;
    ent_t        n1, n2, h;
    logic [31:0] exp_p;
    #1;
    mr1 = !rst && (q1.size() < DEPTH);
    mr2 = !rst && (q2.size() < DEPTH);
    chk("in_ready_pe1", in_ready_pe1, mr1);
    chk("in_ready_pe2", in_ready_pe2, mr2);
    if (in_ready_pe2 === 1'b0) saw_nready2 = 1'b1;
    acc1 = v1 && mr1;
    acc2 = v2 && mr2;
    n1 = '{rd: rd1, data: d1};
    n2 = '{rd: rd2, data: d2};
    @(posedge clk);
    e_we1 = 0; e_a1 = 0; e_d1 = 0;
    e_we2 = 0; e_a2 = 0; e_d2 = 0;
    if (rst) begin
      q1.delete();
      q2.delete();
      owed = 0;
    end else begin
      col = (q1.size() > 0) && (q2.size() > 0) && (q1[0].rd == q2[0].rd) && (q1[0].rd != 0);
      if (col && owed) begin
        h = q2.pop_front(); issue(h, e_we2, e_a2, e_d2); owed = 0;
      end else if (col) begin
        h = q1.pop_front(); issue(h, e_we1, e_a1, e_d1); owed = 1;
      end else begin
        owed = 0;
        if (q1.size() > 0) begin h = q1.pop_front(); issue(h, e_we1, e_a1, e_d1); end
        if (q2.size() > 0) begin h = q2.pop_front(); issue(h, e_we2, e_a2, e_d2); end
      end
      if (acc1) q1.push_back(n1);
      if (acc2) q2.push_back(n2);
    end
    if (e_we1) model_rf[e_a1] = e_d1;
    if (e_we2) model_rf[e_a2] = e_d2;
    exp_p = 32'd0;
`ifdef WB_PENDING_EN
    foreach (q1[i]) exp_p[q1[i].rd] = 1'b1;
    foreach (q2[i]) exp_p[q2[i].rd] = 1'b1;
    if (e_we1) exp_p[e_a1] = 1'b1;
    if (e_we2) exp_p[e_a2] = 1'b1;
    exp_p[0] = 1'b0;
`endif
    #1;
    chk("WE3_PE1", WE3_PE1, e_we1);
    chk("A3_PE1",  A3_PE1,  e_a1);
    chk("WD3_PE1", WD3_PE1, e_d1);
    chk("WE3_PE2", WE3_PE2, e_we2);
    chk("A3_PE2",  A3_PE2,  e_a2);
    chk("WD3_PE2", WD3_PE2, e_d2);
    chk("pending", pending, exp_p);
    if (WE3_PE1 === 1'b1) dut_rf[A3_PE1] = WD3_PE1;
    if (WE3_PE2 === 1'b1) dut_rf[A3_PE2] = WD3_PE2;
  endtask

  task automatic cyc(input logic iv1, input logic [4:0] ir1, input logic [31:0] id1,
                     input logic iv2, input logic [4:0] ir2, input logic [31:0] id2);
    v1 = iv1; rd1 = ir1; d1 = id1;
    v2 = iv2; rd2 = ir2; d2 = id2;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = 32'd0;
      dut_rf[i]   = 32'd0;
    end
    owed = 0;
    saw_nready2 = 0;

    // Reset held with valid asserted on both channels
    rst = 1;
    v1 = 1; rd1 = 5'd5; d1 = 32'h1;
    v2 = 1; rd2 = 5'd6; d2 = 32'h2;
    repeat (3) step();
    rst = 0;
    idle(2);
    chk("post_reset_ready1", in_ready_pe1, 1);
    chk("post_reset_ready2", in_ready_pe2, 1);

    // Single PE1 write, two-cycle latency, one-cycle pulse
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    idle(1);
    chk("t2_we",   WE3_PE1, 1);
    chk("t2_a3",   A3_PE1,  5);
    chk("t2_wd3",  WD3_PE1, 32'hDEADBEEF);
    idle(1);
    chk("t2_we_off",  WE3_PE1, 0);
    chk("t2_a3_off",  A3_PE1,  0);
    chk("t2_wd3_off", WD3_PE1, 0);

    // Collision on x7: PE1 first, PE2 next cycle, later value wins
    cyc(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
    idle(1);
    chk("t3_we1", WE3_PE1, 1);
    chk("t3_wd1", WD3_PE1, 32'h11);
    chk("t3_we2_held", WE3_PE2, 0);
    idle(1);
    chk("t3_we2", WE3_PE2, 1);
    chk("t3_wd2", WD3_PE2, 32'h22);
    chk("t3_we1_off", WE3_PE1, 0);
    chk("t3_x7", dut_rf[7], 32'h22);
    idle(1);

    // Distinct destinations write together; x0 is dropped
    cyc(1, 5'd3, 32'hA, 1, 5'd9, 32'hB);
    idle(1);
    chk("t4_we1", WE3_PE1, 1);
    chk("t4_we2", WE3_PE2, 1);
    chk("t4_a1",  A3_PE1, 3);
    chk("t4_a2",  A3_PE2, 9);
    cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'h5);
    idle(1);
    chk("t4_x0_we2", WE3_PE2, 0);
    idle(1);
    chk("t4_x0_we2_later", WE3_PE2, 0);
    chk("t4_x0_rf", dut_rf[0], 0);

    // Sustained collisions on x4 fill the FIFOs
    saw_nready2 = 0;
    for (int i = 0; i < 10; i++) cyc(1, 5'd4, 32'(i), 1, 5'd4, 32'(100 + i));
    idle(20);
    chk("t5_ready2_fell", saw_nready2, 1);
    chk("t5_rf4", dut_rf[4], model_rf[4]);

    // Fill, then reset mid-operation: nothing drains afterwards
    for (int i = 0; i < 6; i++) cyc(1, 5'd7, 32'(200 + i), 1, 5'd7, 32'(300 + i));
    rst = 1;
    step();
    chk("t6_we1_rst", WE3_PE1, 0);
    chk("t6_we2_rst", WE3_PE2, 0);
    rst = 0;
    idle(6);

    // Scoreboard tracking of x7
    cyc(1, 5'd7, 32'h77, 0, 5'd0, 32'd0);
`ifdef WB_PENDING_EN
    chk("pend7_queued", pending[7], 1);
`endif
    idle(1);
    chk("pend7_write", WE3_PE1, 1);
`ifdef WB_PENDING_EN
    chk("pend7_at_write", pending[7], 1);
`endif
    idle(1);
`ifdef WB_PENDING_EN
    chk("pend7_clear", pending[7], 0);
`endif

    // Randomized traffic with a narrow register range to force collisions
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      v1  = ($urandom_range(0, 9) < 7);
      rd1 = 5'($urandom_range(0, 7));
      d1  = $urandom;
      v2  = ($urandom_range(0, 9) < 7);
      rd2 = 5'($urandom_range(0, 7));
      d2  = $urandom;
      step();
    end
    rst = 0;
    idle(20);
    for (int r = 0; r < 32; r++) chk("rf_final", dut_rf[r], model_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
